// File: rtl/mini_src_mem_pkg.sv
// Shared definitions for the CPU-to-RAM memory access sequencer:
// FSM state encoding, default bus widths and RAM geometry.
package mini_src_mem_pkg;

  localparam int MEM_ADDR_WIDTH = 9;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_WORDS      = 512;
  localparam int CNT_WIDTH      = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_COMPLETE = 3'd3,
    ST_HOLD     = 3'd4
  } mem_state_e;

endpackage

// File: rtl/wait_state_counter.sv
// Down-counter that measures the RAM wait states of one access.
// Loaded once per access, stops at zero and never wraps.
module wait_state_counter
  import mini_src_mem_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  // Count register: load has priority, then saturating decrement.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_count <= {WIDTH{1'b0}};
    end else if (load) begin
      r_count <= load_val;
    end else if (enable && (r_count != {WIDTH{1'b0}})) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero = (r_count == {WIDTH{1'b0}});

endmodule

// File: rtl/memory_access_controller.sv
// Sequencer between the CPU datapath (MAR/MDR) and a synchronous single-port RAM
// with configurable wait states; mem_done lets the control unit stall on an access.
module memory_access_controller
  import mini_src_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic [ADDR_WIDTH-1:0] mar_addr,
  input  logic [DATA_WIDTH-1:0] mdr_out,
  output logic [DATA_WIDTH-1:0] mdatain,
  output logic                  mem_done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [CNT_WIDTH-1:0] LP_WAIT_LOAD = CNT_WIDTH'(WAIT_STATES);

  mem_state_e r_state;
  mem_state_e w_next_state;

  logic                  w_load;
  logic                  w_capture;
  logic                  w_cnt_en;
  logic                  w_cnt_zero;
  logic [DATA_WIDTH-1:0] r_mdatain;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_ram_re;
  logic                  r_ram_we;
  logic                  r_mem_done;
  logic                  r_busy;

  assign w_cnt_en = (r_state == ST_READ) || (r_state == ST_WRITE);

  wait_state_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_wait_cnt (
    .clock    (clock),
    .clear    (clear),
    .load     (w_load),
    .load_val (LP_WAIT_LOAD),
    .enable   (w_cnt_en),
    .zero     (w_cnt_zero)
  );

  // Next-state decode; requests are only looked at in IDLE, COMPLETE and HOLD.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (read_req) begin
          w_next_state = ST_READ;
          w_load       = 1'b1;
        end else if (write_req) begin
          w_next_state = ST_WRITE;
          w_load       = 1'b1;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_READ: begin
        if (w_cnt_zero) begin
          w_next_state = ST_COMPLETE;
          w_capture    = 1'b1;
        end else begin
          w_next_state = ST_READ;
        end
      end
      ST_WRITE: begin
        if (w_cnt_zero) begin
          w_next_state = ST_COMPLETE;
        end else begin
          w_next_state = ST_WRITE;
        end
      end
      ST_COMPLETE: begin
        if (read_req || write_req) begin
          w_next_state = ST_HOLD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Level requests must drop before another access may start.
        if (!read_req && !write_req) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, latched access operands and registered strobes.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state     <= ST_IDLE;
      r_mdatain   <= {DATA_WIDTH{1'b0}};
      r_ram_addr  <= {ADDR_WIDTH{1'b0}};
      r_ram_wdata <= {DATA_WIDTH{1'b0}};
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_mem_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_ram_addr <= mar_addr;
        if (!read_req) begin
          r_ram_wdata <= mdr_out;
        end
      end
      if (w_capture) begin
        r_mdatain <= ram_rdata;
      end
      // Strobes follow the next state so they line up with the state register.
      r_ram_re   <= (w_next_state == ST_READ);
      r_ram_we   <= (w_next_state == ST_WRITE);
      r_mem_done <= (w_next_state == ST_COMPLETE);
      r_busy     <= (w_next_state != ST_IDLE);
    end
  end

  assign mdatain   = r_mdatain;
  assign mem_done  = r_mem_done;
  assign busy      = r_busy;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign ram_re    = r_ram_re;
  assign ram_we    = r_ram_we;

endmodule

// File: tb/tb_memory_access_controller.sv
// Randomized bench for memory_access_controller: a RAM environment model plus a
// word-level reference memory that predicts read data and access timing.
module tb_memory_access_controller;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int W  = 1;

  logic          clock;
  logic          clear;
  logic          read_req;
  logic          write_req;
  logic [AW-1:0] mar_addr;
  logic [DW-1:0] mdr_out;
  logic [DW-1:0] mdatain;
  logic          mem_done;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  // Reference memory: what each word should hold after every intended write.
  logic [DW-1:0] ref_mem [0:511];
  logic [DW-1:0] exp_mdatain = '0;

  // RAM environment: preload port plus DUT write port, one registered read stage
  // after the DUT's registered address (1+W cycles total with W=1).
  logic [DW-1:0] ram_mem [0:511];
  logic [DW-1:0] rdata_q;
  logic          pre_we   = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int n_re = 0, n_we = 0, n_done = 0, n_both = 0;

  memory_access_controller #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .WAIT_STATES(W)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .read_req  (read_req),
    .write_req (write_req),
    .mar_addr  (mar_addr),
    .mdr_out   (mdr_out),
    .mdatain   (mdatain),
    .mem_done  (mem_done),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    rdata_q <= ram_mem[ram_addr];
  end
  assign ram_rdata = rdata_q;

  always @(negedge clock) begin
    if (ram_re) n_re <= n_re + 1;
    if (ram_we) n_we <= n_we + 1;
    if (mem_done) n_done <= n_done + 1;
    if (ram_re && ram_we) n_both <= n_both + 1;
  end

  // One complete access; predicts data, latency, strobe lengths and pulse count.
  task automatic do_access(input bit rd, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int hold, input string tag);
    int s_re, s_we, s_done, lat;
    bit got;
    logic [DW-1:0] exp_d;
    s_re = n_re; s_we = n_we; s_done = n_done;
    @(negedge clock);
    read_req = rd; write_req = wr; mar_addr = addr; mdr_out = data;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        mar_addr = ~addr; mdr_out = ~data;
      end
      if (lat == 2) begin
        total++;
        if (ram_addr !== addr) begin
          bad++; $display("FAIL %s addr_stable: got %h want %h", tag, ram_addr, addr);
        end
        if (!rd) begin
          total++;
          if (ram_wdata !== data) begin
            bad++; $display("FAIL %s wdata_stable: got %h want %h", tag, ram_wdata, data);
          end
        end
      end
      if (mem_done) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL %s timeout: no mem_done within %0d cycles", tag, lat);
    end else if (lat != W + 2) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, W + 2);
    end
    exp_d = rd ? ref_mem[addr] : exp_mdatain;
    total++;
    if (mdatain !== exp_d) begin
      bad++; $display("FAIL %s mdatain: got %h want %h", tag, mdatain, exp_d);
    end
    exp_mdatain = exp_d;
    if (!rd && wr) ref_mem[addr] = data;
    repeat (hold) @(negedge clock);
    if (hold > 0) begin
      total++;
      if (busy !== 1'b1) begin
        bad++; $display("FAIL %s busy_hold: got %b want 1", tag, busy);
      end
    end
    read_req = 1'b0; write_req = 1'b0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_drop: got %b want 0", tag, busy);
    end
    @(negedge clock); #1;
    total++;
    if ((n_done - s_done) != 1) begin
      bad++; $display("FAIL %s done_count: got %0d want 1", tag, n_done - s_done);
    end
    total++;
    if ((n_re - s_re) != (rd ? W + 1 : 0)) begin
      bad++; $display("FAIL %s re_cycles: got %0d want %0d", tag, n_re - s_re, rd ? W + 1 : 0);
    end
    total++;
    if ((n_we - s_we) != (rd ? 0 : W + 1)) begin
      bad++; $display("FAIL %s we_cycles: got %0d want %0d", tag, n_we - s_we, rd ? 0 : W + 1);
    end
  endtask

  task automatic test_reset();
    int lat;
    clear = 1'b0; read_req = 1'b1; write_req = 1'b0; mar_addr = 9'h0A5; mdr_out = 32'h0;
    for (int i = 0; i < 512; i++) begin
      pre_we = 1'b1; pre_addr = AW'(i); pre_data = ref_mem[i];
      @(negedge clock);
      if ((i % 128) == 5) begin
        total++;
        if ({mdatain, mem_done, busy, ram_re, ram_we, ram_addr, ram_wdata} !== '0) begin
          bad++;
          $display("FAIL reset_state: got md=%h done=%b busy=%b re=%b we=%b a=%h wd=%h want all 0",
                   mdatain, mem_done, busy, ram_re, ram_we, ram_addr, ram_wdata);
        end
      end
    end
    pre_we = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    total++;
    if ({busy, ram_re, ram_addr} !== {1'b1, 1'b1, 9'h0A5}) begin
      bad++; $display("FAIL reset_release_accept: got busy=%b re=%b a=%h want 1 1 0a5", busy, ram_re, ram_addr);
    end
    lat = 1;
    while (!mem_done && lat < 20) begin
      @(negedge clock); lat++;
    end
    total++;
    if (mdatain !== 32'hDEADBEEF || lat != W + 2) begin
      bad++; $display("FAIL reset_first_read: got %h lat %0d want deadbeef lat %0d", mdatain, lat, W + 2);
    end
    exp_mdatain = 32'hDEADBEEF;
    read_req = 1'b0;
    @(negedge clock); @(negedge clock);
  endtask

  task automatic test_read();
    do_access(1'b1, 1'b0, 9'h0A5, 32'h0, 2, "read_a5");
    total++;
    if (mdatain !== 32'hDEADBEEF) begin
      bad++; $display("FAIL read_a5_const: got %h want deadbeef", mdatain);
    end
  endtask

  task automatic test_write();
    do_access(1'b0, 1'b1, 9'h1FF, 32'h12345678, 1, "write_1ff");
    do_access(1'b1, 1'b0, 9'h1FF, 32'h0, 0, "readback_1ff");
    total++;
    if (mdatain !== 32'h12345678) begin
      bad++; $display("FAIL readback_1ff_const: got %h want 12345678", mdatain);
    end
  endtask

  task automatic test_simultaneous();
    do_access(1'b1, 1'b1, 9'h033, 32'hCAFEF00D, 1, "simultaneous");
  endtask

  task automatic test_hold();
    do_access(1'b1, 1'b0, 9'h100, 32'h0, 10, "hold_read");
    do_access(1'b0, 1'b1, 9'h101, 32'hA5A5_5A5A, 10, "hold_write");
  endtask

  task automatic test_reset_mid_write();
    int k, s_done;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int rep = 0; rep < 4; rep++) begin
      k = (rep % 2) + 1;
      a = AW'($urandom); d = $urandom;
      @(negedge clock);
      write_req = 1'b1; mar_addr = a; mdr_out = d;
      repeat (k) @(negedge clock);
      total++;
      if (ram_we !== 1'b1) begin
        bad++; $display("FAIL abort_pre_we: got %b want 1", ram_we);
      end
      #2 clear = 1'b0;
      #1;
      total++;
      if ({ram_we, busy, mem_done, ram_addr} !== '0) begin
        bad++; $display("FAIL abort_async: got we=%b busy=%b done=%b a=%h want 0", ram_we, busy, mem_done, ram_addr);
      end
      // The write lands in RAM once one write-phase edge has passed.
      if (k >= 2) ref_mem[a] = d;
      exp_mdatain = '0;
      write_req = 1'b0;
      s_done = n_done;
      repeat (3) @(negedge clock);
      clear = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      total++;
      if (n_done != s_done) begin
        bad++; $display("FAIL abort_no_done: got %0d pulses want 0", n_done - s_done);
      end
      do_access(1'b1, 1'b0, a, 32'h0, 0, "abort_readback");
    end
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 2);
      do_access(op != 1, op != 0, AW'($urandom), $urandom, $urandom_range(0, 3), "random");
    end
    total++;
    if (n_both != 0) begin
      bad++; $display("FAIL re_we_overlap: got %0d cycles want 0", n_both);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = $urandom;
    ref_mem[9'h0A5] = 32'hDEADBEEF;
    test_reset();
    test_read();
    test_write();
    test_simultaneous();
    test_hold();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
